// File: rtl/hdlbc_pkg.sv
// Shared definitions for the HDLBC round engine: FSM encoding, default
// geometry and the X2 half-swap used by the round function.
package hdlbc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } hdlbc_st_e;

   localparam int HDLBC_W      = 16;
   localparam int HDLBC_ROT    = 1;
   localparam int HDLBC_ROUNDS = 24;

endpackage

// Swap the upper and lower halves of a W-bit word.
`ifndef HDLBC_HSWAP
`define HDLBC_HSWAP(x, w) {x[(w)/2-1:0], x[(w)-1:(w)/2]}
`endif

// File: rtl/hdlbc_round.sv
// One combinational HDLBC round: S = {X0,X1,X2,X3} -> {L0, X0, L1, X2}.
// Kept standalone so an unrolled engine can stack several copies.
module hdlbc_round
   import hdlbc_pkg::*;
#(
   parameter int W   = HDLBC_W,
   parameter int ROT = HDLBC_ROT
) (
   input  logic [4*W-1:0] s,
   input  logic [W-1:0]   rk,
   output logic [4*W-1:0] s_nxt
);

   logic [W-1:0] x0, x1, x2, x3;
   logic [W-1:0] rot0, t, kx;

   assign {x0, x1, x2, x3} = s;

   // A zero rotation has no valid part-select form, so it gets its own branch.
   generate
      if (ROT == 0) begin : g_norot
         assign rot0 = x0;
      end else begin : g_rot
         assign rot0 = {x0[W-1-ROT:0], x0[W-1:W-ROT]};
      end
   endgenerate

   assign t     = ~(rot0 & `HDLBC_HSWAP(x2, W));
   assign kx    = t ^ rk ^ x2;
   assign s_nxt = {kx ^ x1, x0, kx ^ x3, x2};

endmodule

// File: rtl/hdlbc_round_engine.sv
// Iterative HDLBC engine: loads a 4-word block, runs ROUNDS rounds (one per
// clock) with keys fetched by rk_idx, then holds the result until taken.
module hdlbc_round_engine
   import hdlbc_pkg::*;
#(
   parameter int W      = HDLBC_W,
   parameter int ROT    = HDLBC_ROT,
   parameter int ROUNDS = HDLBC_ROUNDS,
   localparam int CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4*W-1:0]   in_state,
   output logic [CNT_W-1:0] rk_idx,
   input  logic [W-1:0]     rk,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [4*W-1:0]   out_state,
   output logic             busy
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

   hdlbc_st_e        st;
   logic [CNT_W-1:0] cnt;
   logic [4*W-1:0]   s, s_nxt;

   hdlbc_round #(.W(W), .ROT(ROT)) u_round (
      .s     (s),
      .rk    (rk),
      .s_nxt (s_nxt)
   );

   // Handshake outputs are registered alongside the state so they change
   // exactly on the FSM transition edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= ST_IDLE;
         cnt       <= '0;
         s         <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         rk_idx    <= '0;
      end else begin
         case (st)
            ST_IDLE: begin
               if (in_valid) begin
                  s        <= in_state;
                  cnt      <= '0;
                  rk_idx   <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  st       <= ST_RUN;
               end
            end
            ST_RUN: begin
               s <= s_nxt;
               if (cnt == LAST) begin
                  rk_idx    <= '0;
                  out_valid <= 1'b1;
                  st        <= ST_DONE;
               end else begin
                  cnt    <= cnt + 1'b1;
                  rk_idx <= cnt + 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  cnt       <= '0;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  st        <= ST_IDLE;
               end
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

   assign out_state = s;

endmodule

// File: tb/tb_hdlbc_round_engine.sv
// Directed bench for hdlbc_round_engine across three parameter sets
// (W16/R1, W16/R24, W32/ROT3/R2).
module tb_hdlbc_round_engine;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Instance A: W=16, ROT=1, ROUNDS=1
   logic        iva = 0, ira, ova, ora = 0, bsa;
   logic [63:0] isa = '0, osa;
   logic [0:0]  rkia;
   logic [15:0] rka = '0;

   // Instance B: W=16, ROT=1, ROUNDS=24
   logic        ivb = 0, irb, ovb, orb = 0, bsb;
   logic [63:0] isb = '0, osb;
   logic [4:0]  rkib;
   logic [15:0] rkb;

   // Instance C: W=32, ROT=3, ROUNDS=2
   logic         ivc = 0, irc, ovc, orc = 0, bsc;
   logic [127:0] isc = '0, osc;
   logic [0:0]   rkic;
   logic [31:0]  rkc;

   function automatic logic [15:0] key_b(input logic [4:0] idx);
      return 16'hA5A5 ^ (16'(idx) * 16'h1357);
   endfunction

   function automatic logic [31:0] key_c(input logic [0:0] idx);
      return 32'hC3A5_0F1E + (32'(idx) * 32'h0101_0101);
   endfunction

   function automatic logic [63:0] rnd16(input logic [63:0] st, input logic [15:0] k);
      logic [15:0] a, b, c, d, t, kx;
      {a, b, c, d} = st;
      t  = ~({a[14:0], a[15]} & {c[7:0], c[15:8]});
      kx = t ^ k ^ c;
      return {kx ^ b, a, kx ^ d, c};
   endfunction

   function automatic logic [127:0] rnd32(input logic [127:0] st, input logic [31:0] k);
      logic [31:0] a, b, c, d, t, kx;
      {a, b, c, d} = st;
      t  = ~({a[28:0], a[31:29]} & {c[15:0], c[31:16]});
      kx = t ^ k ^ c;
      return {kx ^ b, a, kx ^ d, c};
   endfunction

   assign rkb = key_b(rkib);
   assign rkc = key_c(rkic);

   hdlbc_round_engine #(.W(16), .ROT(1), .ROUNDS(1)) dut_a (
      .clk(clk), .rst(rst), .in_valid(iva), .in_ready(ira), .in_state(isa),
      .rk_idx(rkia), .rk(rka), .out_valid(ova), .out_ready(ora),
      .out_state(osa), .busy(bsa));

   hdlbc_round_engine #(.W(16), .ROT(1), .ROUNDS(24)) dut_b (
      .clk(clk), .rst(rst), .in_valid(ivb), .in_ready(irb), .in_state(isb),
      .rk_idx(rkib), .rk(rkb), .out_valid(ovb), .out_ready(orb),
      .out_state(osb), .busy(bsb));

   hdlbc_round_engine #(.W(32), .ROT(3), .ROUNDS(2)) dut_c (
      .clk(clk), .rst(rst), .in_valid(ivc), .in_ready(irc), .in_state(isc),
      .rk_idx(rkic), .rk(rkc), .out_valid(ovc), .out_ready(orc),
      .out_state(osc), .busy(bsc));

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      total++; if ({ira, ova, bsa, rkia} !== 4'b1000) begin bad++;
         $display("FAIL reset_a ctl got %b want 1000", {ira, ova, bsa, rkia}); end
      total++; if (osa !== 64'h0) begin bad++;
         $display("FAIL reset_a out_state got %h want 0", osa); end
      total++; if ({irb, ovb, bsb} !== 3'b100 || rkib !== 5'd0) begin bad++;
         $display("FAIL reset_b ctl got %b/%0d want 100/0", {irb, ovb, bsb}, rkib); end
      total++; if (osb !== 64'h0) begin bad++;
         $display("FAIL reset_b out_state got %h want 0", osb); end
      total++; if ({irc, ovc, bsc, rkic} !== 4'b1000 || osc !== 128'h0) begin bad++;
         $display("FAIL reset_c got %b/%h want 1000/0", {irc, ovc, bsc, rkic}, osc); end
   endtask

   task automatic test_single_round(input string nm, input logic [63:0] blk,
                                    input logic [15:0] key, input logic [63:0] exp);
      rka = key; isa = blk; iva = 1'b1;
      @(negedge clk);
      iva = 1'b0;
      total++; if ({ira, bsa, ova} !== 3'b010) begin bad++;
         $display("FAIL %s run_ctl got %b want 010", nm, {ira, bsa, ova}); end
      @(negedge clk);
      total++; if (ova !== 1'b1) begin bad++;
         $display("FAIL %s out_valid got %b want 1", nm, ova); end
      total++; if (osa !== exp) begin bad++;
         $display("FAIL %s out_state got %h want %h", nm, osa, exp); end
      ora = 1'b1;
      @(negedge clk);
      ora = 1'b0;
      total++; if ({ira, ova, bsa} !== 3'b100) begin bad++;
         $display("FAIL %s idle_ctl got %b want 100", nm, {ira, ova, bsa}); end
   endtask

   task automatic test_full24(input logic [63:0] blk);
      logic [63:0] m;
      m = blk;
      isb = blk; ivb = 1'b1;
      @(negedge clk);
      ivb = 1'b0;
      total++; if ({irb, bsb} !== 2'b01) begin bad++;
         $display("FAIL full24 accept got %b want 01", {irb, bsb}); end
      for (int i = 0; i < 24; i++) begin
         total++; if (rkib !== 5'(i) || ovb !== 1'b0) begin bad++;
            $display("FAIL full24 step%0d rk_idx got %0d ov %b want %0d ov 0", i, rkib, ovb, i); end
         m = rnd16(m, key_b(5'(i)));
         @(negedge clk);
      end
      total++; if (ovb !== 1'b1 || rkib !== 5'd0) begin bad++;
         $display("FAIL full24 done got ov %b rk_idx %0d want 1/0", ovb, rkib); end
      total++; if (osb !== m) begin bad++;
         $display("FAIL full24 result got %h want %h", osb, m); end
      orb = 1'b1;
      @(negedge clk);
      orb = 1'b0;
      total++; if ({irb, ovb, bsb} !== 3'b100) begin bad++;
         $display("FAIL full24 idle got %b want 100", {irb, ovb, bsb}); end
   endtask

   task automatic test_backpressure();
      logic [63:0] exp;
      exp = 64'hFDDB_8000_ECCA_0100;
      rka = 16'h1234; isa = 64'h8000_1111_0100_0000; iva = 1'b1;
      @(negedge clk);
      isa = 64'hDEAD_BEEF_0123_4567;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         rka = 16'(i * 16'h0F0F);
         total++; if (osa !== exp || ova !== 1'b1 || ira !== 1'b0) begin bad++;
            $display("FAIL bp hold%0d got %h ov %b ir %b want %h 1 0", i, osa, ova, ira, exp); end
         @(negedge clk);
      end
      iva = 1'b0; ora = 1'b1;
      @(negedge clk);
      ora = 1'b0;
      total++; if ({ira, ova, bsa} !== 3'b100) begin bad++;
         $display("FAIL bp release got %b want 100", {ira, ova, bsa}); end
      // out_ready with nothing pending must leave the engine idle
      ora = 1'b1;
      @(negedge clk);
      ora = 1'b0;
      total++; if ({ira, ova, bsa} !== 3'b100 || osa !== exp) begin bad++;
         $display("FAIL bp stray_ready got %b %h want 100 %h", {ira, ova, bsa}, osa, exp); end
   endtask

   task automatic test_reset_mid_run();
      int guard;
      isb = 64'h0123_4567_89AB_CDEF; ivb = 1'b1;
      @(negedge clk);
      ivb = 1'b0;
      guard = 0;
      while (rkib !== 5'd5 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      total++; if (rkib !== 5'd5 || ovb !== 1'b0) begin bad++;
         $display("FAIL midrst reach got rk_idx %0d want 5", rkib); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++; if ({irb, ovb, bsb} !== 3'b100 || rkib !== 5'd0) begin bad++;
         $display("FAIL midrst state got %b rk_idx %0d want 100/0", {irb, ovb, bsb}, rkib); end
      test_full24(64'hFEDC_BA98_7654_3210);
   endtask

   task automatic test_back_to_back();
      logic [127:0] blks [3];
      logic [127:0] exps [3];
      int idx_in, idx_out, hs_cyc;
      bit adv;
      blks[0] = 128'h0000_0001_0000_0002_0000_0003_0000_0004;
      blks[1] = 128'h8000_0000_FFFF_FFFF_1234_5678_9ABC_DEF0;
      blks[2] = 128'hCAFE_F00D_0BAD_BEEF_5555_AAAA_0F0F_F0F0;
      for (int k = 0; k < 3; k++)
         exps[k] = rnd32(rnd32(blks[k], key_c(1'b0)), key_c(1'b1));
      idx_in = 0; idx_out = 0; hs_cyc = -10; adv = 0;
      isc = blks[0]; ivc = 1'b1; orc = 1'b1;
      for (int cyc = 0; cyc < 60 && idx_out < 3; cyc++) begin
         if (adv) begin
            adv = 0;
            idx_in++;
            if (idx_in < 3) isc = blks[idx_in];
            else ivc = 1'b0;
         end
         if (irc && ivc) begin
            if (idx_in > 0) begin
               total++; if (cyc !== hs_cyc + 1) begin bad++;
                  $display("FAIL b2b gap blk%0d accept at %0d want %0d", idx_in, cyc, hs_cyc + 1); end
            end
            adv = 1;
         end
         if (ovc && orc) begin
            total++; if (osc !== exps[idx_out]) begin bad++;
               $display("FAIL b2b result blk%0d got %h want %h", idx_out, osc, exps[idx_out]); end
            hs_cyc = cyc;
            idx_out++;
         end
         @(negedge clk);
      end
      total++; if (idx_out != 3) begin bad++;
         $display("FAIL b2b timeout got %0d blocks want 3", idx_out); end
      ivc = 1'b0; orc = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_round("zero", 64'h0, 16'h0, 64'hFFFF_0000_FFFF_0000);
      test_single_round("known", 64'h8000_1111_0100_0000, 16'h1234, 64'hFDDB_8000_ECCA_0100);
      test_full24(64'h3C5A_9E17_D204_6B8F);
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
